hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS pipeline.
- Drives the hold and flush inputs of the pipeline registers (IF_IDWrite, IF_Flush, ID_Flush) and the PC write enable.
- Detects load-use hazards, ID-stage taken branches and jumps, and multi-cycle data-memory waits.
- Tracks each memory wait with an FSM and timeout counter; all outputs are consumed by the pipeline registers at their next update edge.

Parameters:
- reg_addr_size, 5, register specifier width
- max_wait, 15, maximum memory-wait cycles before timeout (1..2^cnt_width-1)
- cnt_width, 4, wait counter width
- stat_width, 16, statistics counter width (optional feature only)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- ID_Rs  input  reg_addr_size  rs of instruction in ID
- ID_Rt  input  reg_addr_size  rt of instruction in ID
- ID_UsesRt  input  1  ID instruction reads rt as a source
- ID_BranchTaken  input  1  branch/jump resolved taken in ID
- EX_MemRead  input  1  EX instruction is a load
- EX_Rt  input  reg_addr_size  load destination in EX
- MEM_Req  input  1  MEM stage issuing a data-memory access
- MEM_Ready  input  1  data memory completes access this cycle
- PCWrite  output  1  1 = PC updates
- IF_IDWrite  output  1  1 = IF/ID holds (pipeline-register polarity)
- IF_Flush  output  1  1 = IF/ID loads zero (nop)
- ID_Flush  output  1  1 = ID/EX loads bubble
- Pipe_Freeze  output  1  1 = ID/EX, EX/MEM, MEM/WB hold
- Mem_Timeout  output  1  sticky error, memory wait exceeded max_wait

Behaviour:
- FSM states: RUN, WAIT. Registers: state, wait_cnt[cnt_width], Mem_Timeout.
- Reset (rst=1 at rising edge): state=RUN, wait_cnt=0, Mem_Timeout=0.
- Outputs are combinational from state and inputs, taking effect in the same cycle.
- While rst=1, control outputs are forced to PCWrite=1, IF_IDWrite=0, IF_Flush=0, ID_Flush=0, Pipe_Freeze=0.
- freeze = (state==RUN && MEM_Req && !MEM_Ready) || (state==WAIT && !MEM_Ready && wait_cnt<max_wait).
- load_use = EX_MemRead && EX_Rt!=0 && (EX_Rt==ID_Rs || (ID_UsesRt && EX_Rt==ID_Rt)).
- Priority is freeze > load_use > branch:
  - freeze: PCWrite=0, IF_IDWrite=1, Pipe_Freeze=1, IF_Flush=0, ID_Flush=0.
  - load_use (no freeze): PCWrite=0, IF_IDWrite=1, ID_Flush=1, IF_Flush=0, Pipe_Freeze=0. Exactly one bubble; EX advances, so the hazard clears next cycle.
  - ID_BranchTaken (no freeze, no load_use): IF_Flush=1, PCWrite=1, IF_IDWrite=0.
  - Otherwise: PCWrite=1, all others 0.
- Load-use plus branch in the same cycle: load-use wins. The branch is re-evaluated next cycle from the held ID instruction.
- Transitions:
  - RUN→WAIT when MEM_Req && !MEM_Ready; wait_cnt←1.
  - WAIT, MEM_Ready=1 → RUN; wait_cnt←0. This cycle is not frozen; load_use and branch are evaluated normally.
  - WAIT, !MEM_Ready, wait_cnt<max_wait → stay; wait_cnt+1.
  - WAIT, !MEM_Ready, wait_cnt==max_wait → RUN; Mem_Timeout←1; not frozen this cycle.
- Total frozen cycles for one access: at most max_wait.
- MEM_Req with MEM_Ready=1 in RUN: no stall (zero-wait access).
- Mem_Timeout stays set until rst.
- rst asserted in WAIT returns to RUN immediately.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds outputs Stat_Stall, Stat_Bubble, Stat_Flush, each stat_width bits.
  - Each counts cycles with freeze, load_use-selected, and branch-selected respectively.
  - Saturating at all-ones; cleared by rst.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding: HZ_RUN=1'b0, HZ_WAIT=1'b1
  - constant REG_ZERO=5'd0
- One natural sub-module: hazard_mem_wait, containing the RUN/WAIT FSM, wait_cnt and Mem_Timeout, with output freeze.
- Load-use and branch priority logic stays in the top module.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rt=8, ID_Rs=8 → one cycle PCWrite=0, IF_IDWrite=1, ID_Flush=1. Next cycle with EX_MemRead=0 → PCWrite=1.
- Zero-register and unused rt: EX_Rt=0, ID_Rs=0 → no stall. EX_Rt=9, ID_Rt=9, ID_UsesRt=0 → no stall.
- Branch: ID_BranchTaken=1, no hazard → IF_Flush=1, PCWrite=1 for one cycle. Load-use plus branch together → ID_Flush=1 and IF_Flush=0.
- Memory wait: MEM_Req=1, MEM_Ready low for 3 cycles then high → Pipe_Freeze=1 for exactly 3 cycles, 0 on the ready cycle, state back to RUN.
- Timeout: max_wait=15, MEM_Ready held 0 → 15 frozen cycles, then Mem_Timeout=1 and it stays set. rst=1 → Mem_Timeout=0, state=RUN.
- Reset mid-wait: rst pulse on wait cycle 2 → next cycle no freeze, wait_cnt=0. With HAZARD_STATS_EN defined, all stat counters read 0 after the reset.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Contents:
//   hz_state_e  memory-wait FSM state (HZ_RUN, HZ_WAIT)
//   hz_sel_e    which pipeline action the controller selected this cycle
//   REG_ZERO    architectural zero register specifier (never a real dependency)
package hazard_pkg;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_WAIT = 1'b1
    } hz_state_e;

    typedef enum logic [1:0] {
        SEL_NONE     = 2'd0,
        SEL_FREEZE   = 2'd1,
        SEL_LOAD_USE = 2'd2,
        SEL_BRANCH   = 2'd3
    } hz_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_mem_wait.sv
// rtl/hazard_mem_wait.sv - data-memory wait tracker with bounded freeze and sticky timeout
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   mem_req_i    MEM stage issuing a data-memory access
//   mem_ready_i  data memory completes the access this cycle
//   freeze_o     combinational: hold the back end of the pipeline this cycle
//   timeout_o    sticky: an access exceeded max_wait frozen cycles
module hazard_mem_wait
    import hazard_pkg::*;
#(
    parameter int max_wait  = 15,
    parameter int cnt_width = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req_i,
    input  logic mem_ready_i,
    output logic freeze_o,
    output logic timeout_o
);

    localparam logic [cnt_width-1:0] MAX_CNT = cnt_width'(max_wait);
    localparam logic [cnt_width-1:0] ONE     = cnt_width'(1);

    hz_state_e             state_q, state_d;
    logic [cnt_width-1:0]  wait_cnt_q, wait_cnt_d;
    logic                  timeout_q, timeout_d;

    // wait_cnt counts frozen cycles already spent on the access; the RUN
    // cycle that starts the wait is frozen cycle 1, so freezing stops once
    // wait_cnt reaches max_wait and the total never exceeds max_wait.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        freeze_o   = 1'b0;
        unique case (state_q)
            HZ_RUN: begin
                if (mem_req_i && !mem_ready_i) begin
                    freeze_o   = 1'b1;
                    state_d    = HZ_WAIT;
                    wait_cnt_d = ONE;
                end
            end
            HZ_WAIT: begin
                if (mem_ready_i) begin
                    state_d    = HZ_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q < MAX_CNT) begin
                    freeze_o   = 1'b1;
                    wait_cnt_d = wait_cnt_q + ONE;
                end else begin
                    // Give up: release the pipeline and flag the error.
                    state_d    = HZ_RUN;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b1;
                end
            end
            default: begin
                state_d    = HZ_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HZ_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - central hazard controller for the 5-stage pipeline
//
// Optional feature macro: HAZARD_STATS_EN (adds saturating event counters).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   ID_Rs, ID_Rt      source specifiers of the instruction in ID
//   ID_UsesRt         ID instruction reads rt
//   ID_BranchTaken    branch/jump resolved taken in ID
//   EX_MemRead, EX_Rt load in EX and its destination
//   MEM_Req, MEM_Ready data-memory handshake of the MEM stage
//   PCWrite           1 = PC updates
//   IF_IDWrite        1 = IF/ID holds
//   IF_Flush          1 = IF/ID loads a nop
//   ID_Flush          1 = ID/EX loads a bubble
//   Pipe_Freeze       1 = ID/EX, EX/MEM, MEM/WB hold
//   Mem_Timeout       sticky memory-wait timeout
//   Stat_Stall/Bubble/Flush  (HAZARD_STATS_EN only) cycle counters
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int reg_addr_size = 5,
    parameter int max_wait      = 15,
    parameter int cnt_width     = 4,
    parameter int stat_width    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [reg_addr_size-1:0] ID_Rs,
    input  logic [reg_addr_size-1:0] ID_Rt,
    input  logic                     ID_UsesRt,
    input  logic                     ID_BranchTaken,
    input  logic                     EX_MemRead,
    input  logic [reg_addr_size-1:0] EX_Rt,
    input  logic                     MEM_Req,
    input  logic                     MEM_Ready,
    output logic                     PCWrite,
    output logic                     IF_IDWrite,
    output logic                     IF_Flush,
    output logic                     ID_Flush,
    output logic                     Pipe_Freeze,
`ifdef HAZARD_STATS_EN
    output logic [stat_width-1:0]    Stat_Stall,
    output logic [stat_width-1:0]    Stat_Bubble,
    output logic [stat_width-1:0]    Stat_Flush,
`endif
    output logic                     Mem_Timeout
);

    if (max_wait < 1 || max_wait > (2 ** cnt_width) - 1) begin : g_bad_max_wait
        $error("hazard_stall_ctrl: max_wait must fit in 1..2^cnt_width-1");
    end
    if (stat_width < 1) begin : g_bad_stat_width
        $error("hazard_stall_ctrl: stat_width must be at least 1");
    end

    localparam logic [reg_addr_size-1:0] ZERO_REG = reg_addr_size'(REG_ZERO);

    logic    freeze;
    logic    load_use;
    hz_sel_e sel;

    hazard_mem_wait #(
        .max_wait  (max_wait),
        .cnt_width (cnt_width)
    ) u_mem_wait (
        .clk         (clk),
        .rst         (rst),
        .mem_req_i   (MEM_Req),
        .mem_ready_i (MEM_Ready),
        .freeze_o    (freeze),
        .timeout_o   (Mem_Timeout)
    );

    // A load into $zero never produces a value, so it cannot create a hazard.
    assign load_use = EX_MemRead && (EX_Rt != ZERO_REG) &&
                      ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    // A load-use bubble outranks a branch: the held ID instruction re-resolves
    // its branch next cycle, so nothing is lost by deferring it.
    always_comb begin
        sel = SEL_NONE;
        if (!rst) begin
            if (freeze) begin
                sel = SEL_FREEZE;
            end else if (load_use) begin
                sel = SEL_LOAD_USE;
            end else if (ID_BranchTaken) begin
                sel = SEL_BRANCH;
            end
        end
    end

    always_comb begin
        PCWrite     = 1'b1;
        IF_IDWrite  = 1'b0;
        IF_Flush    = 1'b0;
        ID_Flush    = 1'b0;
        Pipe_Freeze = 1'b0;
        unique case (sel)
            SEL_FREEZE: begin
                PCWrite     = 1'b0;
                IF_IDWrite  = 1'b1;
                Pipe_Freeze = 1'b1;
            end
            SEL_LOAD_USE: begin
                PCWrite    = 1'b0;
                IF_IDWrite = 1'b1;
                ID_Flush   = 1'b1;
            end
            SEL_BRANCH: begin
                IF_Flush = 1'b1;
            end
            default: begin
                PCWrite = 1'b1;
            end
        endcase
    end

`ifdef HAZARD_STATS_EN
    localparam logic [stat_width-1:0] STAT_ONE = stat_width'(1);

    logic [stat_width-1:0] stat_stall_q, stat_bubble_q, stat_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_q  <= '0;
            stat_bubble_q <= '0;
            stat_flush_q  <= '0;
        end else begin
            if (sel == SEL_FREEZE && stat_stall_q != '1) begin
                stat_stall_q <= stat_stall_q + STAT_ONE;
            end
            if (sel == SEL_LOAD_USE && stat_bubble_q != '1) begin
                stat_bubble_q <= stat_bubble_q + STAT_ONE;
            end
            if (sel == SEL_BRANCH && stat_flush_q != '1) begin
                stat_flush_q <= stat_flush_q + STAT_ONE;
            end
        end
    end

    assign Stat_Stall  = stat_stall_q;
    assign Stat_Bubble = stat_bubble_q;
    assign Stat_Flush  = stat_flush_q;
`endif

endmodule
